lock_seq_ctrl: RTL and testbench

LOCK_SEQ_CTRL -- requirements
Module: lock_seq_ctrl

---
 rtl/lock_pkg.sv | 22 ++
 rtl/lock_seq_timer.sv | 45 ++++
 rtl/lock_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_lock_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the converter lock sequencer.
//   State codes, source vector layout and timer/counter widths used by
//   lock_seq_ctrl and lock_seq_timer.
//   Source vector layout {force, src[3:0]}:
//     bit0 phaselock1, bit1 phaselock2, bit2 fastlock, bit3 phase-status fault,
//     bit4 force block.
package lock_pkg;

  localparam int unsigned TIMER_W   = 16;
  localparam int unsigned SRC_W     = 4;
  localparam int unsigned SRCV_W    = 5;
  localparam int unsigned EVT_W     = 8;
  localparam int unsigned SRC_FORCE = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BLOCK    = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_DEBOUNCE = 2'd3
  } lock_state_e;

endpackage

// File: rtl/lock_seq_timer.sv
// lock_seq_timer: loadable down-counter with a registered done flag.
//   clk_i      : clock (rising edge)
//   rst_i      : asynchronous active-high reset, counter loads RESET_VAL
//   load_i     : load load_val_i this cycle (takes priority over counting)
//   load_val_i : value to load
//   done_o     : count is at 1 or 0, i.e. the current cycle is the last one
// The counter stops at zero; it never wraps.
module lock_seq_timer
  import lock_pkg::*;
#(
  parameter int unsigned RESET_VAL = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               done_q;

  // Next count: load, else decrement down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= TIMER_W'(RESET_VAL);
      done_q <= (RESET_VAL <= 32'd1);
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d <= TIMER_W'(1));
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/lock_seq_ctrl.sv
// lock_seq_ctrl: block/deblock sequencer for the converter lock command.
//   Any unmasked source request (or force) blocks the converter for at least
//   MIN_BLOCK_CYC cycles; deblock needs an operator release with sources quiet,
//   then DEBOUNCE_CYC quiet cycles.
// Ports:
//   i_clk_20M     : clock
//   i_reset       : asynchronous active-high reset (comes up blocked)
//   i_src_req     : block requests {phase fault, fastlock, phaselock2, phaselock1}
//   i_src_mask    : per-source ignore
//   i_force_block : unmaskable block request
//   i_release     : operator release pulse
//   o_lock        : block command
//   o_state       : state code (RUN/BLOCK/WAIT_REL/DEBOUNCE)
//   o_first_src   : sources {force, src} in the triggering cycle
//   o_fault_latch : sticky OR of sources since last deblock
//   o_evt_cnt     : saturating block event counter
// Build option: LOCK_SEQ_AUTO_REL_EN -- WAIT_REL leaves on the first quiet
//   cycle without waiting for i_release.
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned MIN_BLOCK_CYC = 20000,
  parameter int unsigned DEBOUNCE_CYC  = 2000
) (
  input  logic              i_clk_20M,
  input  logic              i_reset,
  input  logic [SRC_W-1:0]  i_src_req,
  input  logic [SRC_W-1:0]  i_src_mask,
  input  logic              i_force_block,
  input  logic              i_release,
  output logic              o_lock,
  output logic [1:0]        o_state,
  output logic [SRCV_W-1:0] o_first_src,
  output logic [SRCV_W-1:0] o_fault_latch,
  output logic [EVT_W-1:0]  o_evt_cnt
);

  lock_state_e        state_q, state_d;
  logic               lock_q, lock_d;
  logic [SRCV_W-1:0]  first_q, first_d;
  logic [SRCV_W-1:0]  latch_q, latch_d;
  logic [EVT_W-1:0]   evt_q, evt_d;

  logic [SRCV_W-1:0]  srcs_c;
  logic               active_c;
  logic               rel_ok_c;
  logic               evt_inc_c;
  logic               timer_load_c;
  logic [TIMER_W-1:0] timer_val_c;
  logic               timer_done;

  // Effective sources this cycle.
  always_comb begin
    srcs_c            = '0;
    srcs_c[SRC_W-1:0] = i_src_req & ~i_src_mask;
    srcs_c[SRC_FORCE] = i_force_block;
    active_c          = |srcs_c;
  end

`ifdef LOCK_SEQ_AUTO_REL_EN
  logic unused_release_c;
  assign unused_release_c = i_release;
  assign rel_ok_c         = ~active_c;
`else
  // A release coinciding with active sources is dropped, not remembered.
  assign rel_ok_c = i_release & ~active_c;
`endif

  // Shared timer is reloaded on every state change.
  lock_seq_timer #(
    .RESET_VAL (MIN_BLOCK_CYC)
  ) u_timer (
    .clk_i      (i_clk_20M),
    .rst_i      (i_reset),
    .load_i     (timer_load_c),
    .load_val_i (timer_val_c),
    .done_o     (timer_done)
  );

  // State and output registers.
  always_ff @(posedge i_clk_20M or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_BLOCK;
      lock_q  <= 1'b1;
      first_q <= '0;
      latch_q <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      first_q <= first_d;
      latch_q <= latch_d;
      evt_q   <= evt_d;
    end
  end

  // Next state and timer reload.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:      if (active_c)   state_d = ST_BLOCK;
      ST_BLOCK:    if (timer_done) state_d = ST_WAIT_REL;
      ST_WAIT_REL: if (rel_ok_c)   state_d = ST_DEBOUNCE;
      ST_DEBOUNCE: begin
        if (active_c)        state_d = ST_BLOCK;
        else if (timer_done) state_d = ST_RUN;
      end
      default:               state_d = ST_BLOCK;
    endcase

    timer_load_c = (state_d != state_q);
    unique case (state_d)
      ST_BLOCK:    timer_val_c = TIMER_W'(MIN_BLOCK_CYC);
      ST_DEBOUNCE: timer_val_c = TIMER_W'(DEBOUNCE_CYC);
      default:     timer_val_c = '0;
    endcase
  end

  // Output next values: capture, sticky latch, event count.
  always_comb begin
    first_d   = first_q;
    latch_d   = latch_q;
    evt_inc_c = 1'b0;
    lock_d    = (state_d != ST_RUN);

    if (state_q == ST_RUN) begin
      if (active_c) begin
        first_d   = srcs_c;
        latch_d   = latch_q | srcs_c;
        evt_inc_c = 1'b1;
      end
    end else begin
      latch_d = latch_q | srcs_c;
      if (state_q == ST_DEBOUNCE) begin
        if (active_c) begin
          evt_inc_c = 1'b1;
        end else if (state_d == ST_RUN) begin
          first_d = '0;
          latch_d = '0;
        end
      end
    end

    evt_d = (evt_inc_c && (evt_q != '1)) ? evt_q + EVT_W'(1) : evt_q;
  end

  assign o_lock        = lock_q;
  assign o_state       = state_q;
  assign o_first_src   = first_q;
  assign o_fault_latch = latch_q;
  assign o_evt_cnt     = evt_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// tb_lock_seq_ctrl: scoreboard bench for lock_seq_ctrl (MIN_BLOCK_CYC=10,
//   DEBOUNCE_CYC=4). Honours LOCK_SEQ_AUTO_REL_EN when defined.
module tb_lock_seq_ctrl;

  localparam int MIN = 10;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [3:0] i_src_req = '0;
  logic [3:0] i_src_mask = '0;
  logic       i_force_block = 1'b0;
  logic       i_release = 1'b0;
  logic       o_lock;
  logic [1:0] o_state;
  logic [4:0] o_first_src;
  logic [4:0] o_fault_latch;
  logic [7:0] o_evt_cnt;

  lock_seq_ctrl #(
    .MIN_BLOCK_CYC (MIN),
    .DEBOUNCE_CYC  (DEB)
  ) dut (
    .i_clk_20M     (clk),
    .i_reset       (i_reset),
    .i_src_req     (i_src_req),
    .i_src_mask    (i_src_mask),
    .i_force_block (i_force_block),
    .i_release     (i_release),
    .o_lock        (o_lock),
    .o_state       (o_state),
    .o_first_src   (o_first_src),
    .o_fault_latch (o_fault_latch),
    .o_evt_cnt     (o_evt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       lk;
    logic [4:0] fs;
    logic [4:0] fl;
    logic [7:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase number, cycles spent in the phase, captured values.
  int         m_phase;
  int         m_age;
  logic [4:0] m_first;
  logic [4:0] m_latch;
  int         m_evt;

  task automatic model_reset();
    m_phase = 1; m_age = 0; m_first = '0; m_latch = '0; m_evt = 0;
  endtask

  task automatic model_step(input logic [3:0] req, input logic [3:0] msk,
                            input logic frc, input logic rel);
    logic [4:0] s;
    bit act;
    bit auto_rel;
    s = {frc, req & ~msk};
    act = |s;
    auto_rel = 1'b0;
`ifdef LOCK_SEQ_AUTO_REL_EN
    auto_rel = 1'b1;
`endif
    if (m_phase == 0) begin
      if (act) begin
        m_phase = 1; m_age = 0; m_first = s; m_latch = m_latch | s;
        m_evt = (m_evt < 255) ? m_evt + 1 : 255;
      end
    end else begin
      m_latch = m_latch | s;
      if (m_phase == 1) begin
        m_age++;
        if (m_age == MIN) begin m_phase = 2; m_age = 0; end
      end else if (m_phase == 2) begin
        if (!act && (rel || auto_rel)) begin m_phase = 3; m_age = 0; end
      end else begin
        if (act) begin
          m_phase = 1; m_age = 0;
          m_evt = (m_evt < 255) ? m_evt + 1 : 255;
        end else begin
          m_age++;
          if (m_age == DEB) begin
            m_phase = 0; m_age = 0; m_first = '0; m_latch = '0;
          end
        end
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.st = 2'(m_phase);
    e.lk = (m_phase != 0);
    e.fs = m_first;
    e.fl = m_latch;
    e.ec = 8'(m_evt);
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per clock, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (o_state !== e.st || o_lock !== e.lk || o_first_src !== e.fs ||
            o_fault_latch !== e.fl || o_evt_cnt !== e.ec) begin
          errors++;
          $display("FAIL cycle t=%0t state=%0d/%0d lock=%0b/%0b first=%b/%b latch=%b/%b evt=%0d/%0d (actual/required)",
                   $time, o_state, e.st, o_lock, e.lk, o_first_src, e.fs,
                   o_fault_latch, e.fl, o_evt_cnt, e.ec);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] msk,
                       input logic frc, input logic rel);
    i_src_req = req; i_src_mask = msk; i_force_block = frc; i_release = rel;
    @(posedge clk);
    model_step(req, msk, frc, rel);
    push_exp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    i_src_req = '0; i_src_mask = '0; i_force_block = 1'b0; i_release = 1'b0;
    i_reset = 1'b1;
    model_reset();
    repeat (n) begin
      @(posedge clk);
      push_exp();
      @(negedge clk);
    end
    i_reset = 1'b0;
  endtask

  // Release until the model says RUN (bounded), then confirm the DUT is there.
  task automatic to_run();
    int b;
    b = 0;
    while (m_phase != 0 && b < 40) begin
      drive(4'h0, 4'h0, 1'b0, 1'b1);
      b++;
    end
    chk("to_run_state", int'(o_state), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-up sequence
    do_reset(3);
    chk("rst_state", int'(o_state), 1);
    chk("rst_lock", int'(o_lock), 1);
    chk("rst_evt", int'(o_evt_cnt), 0);
    idle(9);
    chk("pwr_block9", int'(o_state), 1);
    idle(1);
    chk("pwr_wait_rel", int'(o_state), 2);
    drive(4'h0, 4'h0, 1'b0, 1'b1);
    chk("pwr_debounce", int'(o_state), 3);
    idle(3);
    chk("pwr_deb3_lock", int'(o_lock), 1);
    idle(1);
    chk("pwr_run_lock", int'(o_lock), 0);
    chk("pwr_run_state", int'(o_state), 0);

    // Two sources, one cycle
    drive(4'b0011, 4'h0, 1'b0, 1'b0);
    chk("blk_lock", int'(o_lock), 1);
    chk("blk_first", int'(o_first_src), 5'b00011);
    chk("blk_evt", int'(o_evt_cnt), 1);
    idle(9);
    chk("blk_min9", int'(o_state), 1);
    idle(1);
    chk("blk_min10", int'(o_state), 2);
    to_run();

    // Mask and force
    repeat (3) drive(4'b0001, 4'b0001, 1'b0, 1'b0);
    chk("mask_noblock", int'(o_state), 0);
    drive(4'b0001, 4'b0001, 1'b1, 1'b0);
    chk("force_first", int'(o_first_src), 5'b10000);
    chk("force_evt", int'(o_evt_cnt), 2);
    to_run();

    // Ignored releases
    drive(4'b0100, 4'h0, 1'b0, 1'b1);
    repeat (MIN) drive(4'h0, 4'h0, 1'b0, 1'b1);
    chk("rel_in_block", int'(o_state), 2);
    repeat (3) drive(4'b0100, 4'h0, 1'b0, 1'b1);
    chk("rel_active", int'(o_state), 2);
`ifndef LOCK_SEQ_AUTO_REL_EN
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    chk("rel_not_stored", int'(o_state), 2);
`endif
    drive(4'h0, 4'h0, 1'b0, 1'b1);
    chk("rel_quiet", int'(o_state), 3);
    chk("rel_latch", int'(o_fault_latch), 5'b00100);
    to_run();

    // Re-block from debounce cycle 3
    drive(4'b0001, 4'h0, 1'b0, 1'b0);
    idle(MIN);
    drive(4'h0, 4'h0, 1'b0, 1'b1);
    chk("reblk_deb", int'(o_state), 3);
    idle(2);
    drive(4'b0010, 4'h0, 1'b0, 1'b0);
    chk("reblk_state", int'(o_state), 1);
    chk("reblk_evt", int'(o_evt_cnt), 5);
    chk("reblk_first", int'(o_first_src), 5'b00001);
    chk("reblk_latch", int'(o_fault_latch), 5'b00011);
    idle(9);
    chk("reblk_min9", int'(o_state), 1);
    idle(1);
    chk("reblk_min10", int'(o_state), 2);
    to_run();

    // Reset mid-debounce
    drive(4'b1000, 4'h0, 1'b0, 1'b0);
    idle(MIN);
    drive(4'h0, 4'h0, 1'b0, 1'b1);
    idle(2);
    do_reset(2);
    chk("midrst_state", int'(o_state), 1);
    chk("midrst_evt", int'(o_evt_cnt), 0);
    chk("midrst_latch", int'(o_fault_latch), 0);
    idle(MIN);
    chk("midrst_wait", int'(o_state), 2);
    to_run();

    // Random traffic
    repeat (600) begin
      logic [3:0] rq;
      rq = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      drive(rq, 4'($urandom), ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 3) == 0));
    end
    to_run();

    // Event counter saturation
    do_reset(1);
    idle(MIN);
    to_run();
    for (int e = 0; e < 300; e++) begin
      drive(4'b0001, 4'h0, 1'b0, 1'b0);
      idle(MIN);
      drive(4'h0, 4'h0, 1'b0, 1'b1);
      idle(2);
    end
    chk("evt_sat", int'(o_evt_cnt), 255);
    to_run();
    chk("evt_sat_run", int'(o_evt_cnt), 255);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
